sevseg_scan_capture: RTL and testbench

//  Receive side of the board 7-segment interface. Watches the active-low anode enables (en)
//  and active-low segment lines (disp) driven by a display driver, and rebuilds a 32-bit hex value.

---
 rtl/sevseg_scan_capture_pkg.sv | 34 +++
 rtl/sevseg_scan_capture_if.sv | 15 +
 rtl/sevseg_scan_capture_pattern_decode.sv | 35 +++
 rtl/sevseg_scan_capture.sv | 149 ++++++++++++++
 tb/tb_sevseg_scan_capture.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/sevseg_scan_capture_pkg.sv
// Shared 7-segment definitions: active-low glyph patterns, anode idle value,
// capture FSM states and a one-hot-low anode check.
package sevseg_pkg;

  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0010000;
  localparam logic [6:0] SEG_A = 7'b0001000;
  localparam logic [6:0] SEG_B = 7'b0000011;
  localparam logic [6:0] SEG_C = 7'b1000110;
  localparam logic [6:0] SEG_D = 7'b0100001;
  localparam logic [6:0] SEG_E = 7'b0000110;
  localparam logic [6:0] SEG_F = 7'b0001110;

  localparam logic [7:0] ANODE_OFF = 8'hFF;
  localparam logic [6:0] SEG_OFF   = 7'h7F;

  typedef enum logic [1:0] {IDLE, SETTLE, CAPTURED} state_t;

  // True when exactly one anode enable is driven low.
  function automatic logic single_anode(input logic [7:0] en_n);
    logic [7:0] a;
    a = ~en_n;
    return (a != 8'd0) && ((a & (a - 8'd1)) == 8'd0);
  endfunction

endpackage

// File: rtl/sevseg_scan_capture_if.sv
// Display-side bus: raw anode/segment lines in, rebuilt frame and flags out.
interface sevseg_scan_capture_if;
  logic [6:0]  disp;
  logic [7:0]  en;
  logic [31:0] value;
  logic [7:0]  dig_valid;
  logic        frame_done;
  logic        seg_err;
  logic        stale;

  modport master (output disp, en,
                  input  value, dig_valid, frame_done, seg_err, stale);
  modport slave  (input  disp, en,
                  output value, dig_valid, frame_done, seg_err, stale);
endinterface

// File: rtl/sevseg_scan_capture_pattern_decode.sv
// Maps an active-low segment pattern back to its hex nibble; exact match only.
module sevseg_pattern_decode
  import sevseg_pkg::*;
(
  input  logic [6:0] disp_i,
  output logic       hit_o,
  output logic [3:0] nib_o
);

  // Table lookup; anything not in the glyph set is a miss.
  always_comb begin
    hit_o = 1'b1;
    nib_o = 4'h0;
    case (disp_i)
      SEG_0:   nib_o = 4'h0;
      SEG_1:   nib_o = 4'h1;
      SEG_2:   nib_o = 4'h2;
      SEG_3:   nib_o = 4'h3;
      SEG_4:   nib_o = 4'h4;
      SEG_5:   nib_o = 4'h5;
      SEG_6:   nib_o = 4'h6;
      SEG_7:   nib_o = 4'h7;
      SEG_8:   nib_o = 4'h8;
      SEG_9:   nib_o = 4'h9;
      SEG_A:   nib_o = 4'hA;
      SEG_B:   nib_o = 4'hB;
      SEG_C:   nib_o = 4'hC;
      SEG_D:   nib_o = 4'hD;
      SEG_E:   nib_o = 4'hE;
      SEG_F:   nib_o = 4'hF;
      default: hit_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/sevseg_scan_capture.sv
// Receive side of a multiplexed 7-segment display: synchronises the pins,
// waits for each digit to settle, decodes it into a shadow frame and publishes
// the frame once every masked digit has been seen.
module sevseg_scan_capture
  import sevseg_pkg::*;
#(
  parameter int         SETTLE_CYC  = 16,
  parameter int         TIMEOUT_CYC = 2_000_000,
  parameter logic [7:0] DIGIT_MASK  = 8'hFF
) (
  input  logic                  CLK100MHZ,
  input  logic                  CPU_RESETN,
  sevseg_scan_capture_if.slave  bus
);

  localparam int          CNT_W  = $clog2(SETTLE_CYC + 1);
  localparam int          TO_W   = $clog2(TIMEOUT_CYC + 1);
  localparam logic [14:0] IN_RST = {ANODE_OFF, SEG_OFF};

  logic [14:0]      sync1_q, sync_q, prev_q;
  logic [7:0]       dig_sel;
  logic             single, chg, smp, hit, frame_pub;
  logic [3:0]       nib;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0][3:0]  shadow_q, shadow_d, value_q;
  logic [7:0]       ok_q, ok_d, seen_q, seen_d, dv_q;
  logic             fd_q, err_q;
  logic [TO_W-1:0]  to_q;

  // Two-flop synchronisers on {en,disp}, plus last synced value for change detect.
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      sync1_q <= IN_RST;
      sync_q  <= IN_RST;
      prev_q  <= IN_RST;
    end else begin
      sync1_q <= {bus.en, bus.disp};
      sync_q  <= sync1_q;
      prev_q  <= sync_q;
    end
  end

  assign dig_sel = ~sync_q[14:7];
  assign single  = single_anode(sync_q[14:7]);
  assign chg     = (sync_q != prev_q);

  sevseg_pattern_decode u_dec (
    .disp_i (sync_q[6:0]),
    .hit_o  (hit),
    .nib_o  (nib)
  );

  // State and settle counter registers.
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Dwell tracking: count stable cycles, take exactly one sample per dwell.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    smp     = 1'b0;
    case (state_q)
      IDLE: begin
        if (single) begin
          state_d = SETTLE;
          cnt_d   = CNT_W'(1);
        end
      end
      SETTLE: begin
        if (chg) begin
          if (!single) state_d = IDLE;
          else         cnt_d   = CNT_W'(1);
        end else if (cnt_q == CNT_W'(SETTLE_CYC)) begin
          smp     = 1'b1;
          state_d = CAPTURED;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      CAPTURED: begin
        if (chg) begin
          state_d = single ? SETTLE : IDLE;
          cnt_d   = CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Shadow update; the seen clear on publish happens before this cycle's sample is ORed in.
  always_comb begin
    frame_pub = ((seen_q & DIGIT_MASK) == DIGIT_MASK);
    shadow_d  = shadow_q;
    ok_d      = ok_q;
    seen_d    = frame_pub ? 8'd0 : seen_q;
    if (smp) seen_d = seen_d | dig_sel;
    for (int i = 0; i < 8; i++) begin
      if (smp && dig_sel[i]) begin
        ok_d[i] = hit;
        if (hit) shadow_d[i] = nib;
      end
    end
  end

  // Shadow frame, publish registers and one-cycle status pulses.
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      shadow_q <= '0;
      ok_q     <= '0;
      seen_q   <= '0;
      value_q  <= '0;
      dv_q     <= '0;
      fd_q     <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      ok_q     <= ok_d;
      seen_q   <= seen_d;
      fd_q     <= frame_pub;
      err_q    <= smp & ~hit;
      if (frame_pub) begin
        value_q <= shadow_q;
        dv_q    <= ok_q & DIGIT_MASK;
      end
    end
  end

  // Staleness counter: reloads only on a recognised sample, saturates rather than wraps.
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN)                      to_q <= TO_W'(TIMEOUT_CYC);
    else if (smp && hit)                  to_q <= '0;
    else if (to_q != TO_W'(TIMEOUT_CYC))  to_q <= to_q + TO_W'(1);
  end

  assign bus.value      = value_q;
  assign bus.dig_valid  = dv_q;
  assign bus.frame_done = fd_q;
  assign bus.seg_err    = err_q;
  assign bus.stale      = (to_q == TO_W'(TIMEOUT_CYC));

endmodule

// File: tb/tb_sevseg_scan_capture.sv
// Scoreboard bench: a digit-level model pushes expected frames as digits are
// driven; a negedge monitor pops them when frame_done fires.
module tb_sevseg_scan_capture;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic [7:0] drv_en   = 8'hFF;
  logic [6:0] drv_disp = 7'h7F;

  sevseg_scan_capture_if bus0 ();
  sevseg_scan_capture_if bus1 ();
  assign bus0.en   = drv_en;
  assign bus0.disp = drv_disp;
  assign bus1.en   = drv_en;
  assign bus1.disp = drv_disp;

  sevseg_scan_capture #(.SETTLE_CYC(16), .TIMEOUT_CYC(300), .DIGIT_MASK(8'hFF)) u_dut (
    .CLK100MHZ (clk), .CPU_RESETN (rst_n), .bus (bus0));

  sevseg_scan_capture #(.SETTLE_CYC(16), .TIMEOUT_CYC(300), .DIGIT_MASK(8'h01)) u_dut1 (
    .CLK100MHZ (clk), .CPU_RESETN (rst_n), .bus (bus1));

  logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  typedef struct packed {
    logic [31:0] val;
    logic [7:0]  dv;
  } frame_t;

  frame_t      exp_q [$];
  logic [3:0]  m_nib [8];
  logic [7:0]  m_ok   = 8'h00;
  logic [7:0]  m_seen = 8'h00;
  int          m_err = 0, m_pushed = 0;
  int          n_chk = 0, n_err = 0;
  int          n_frames = 0, n_frames1 = 0, n_seg = 0;
  logic [31:0] last_val = '0;
  logic [7:0]  last_dv  = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, obs, exp);
    end
  endtask

  // Model of one accepted sample of digit i.
  task automatic mdl_sample(input int i, input logic [6:0] pat);
    logic        hit;
    logic [3:0]  n;
    logic [31:0] v;
    hit = 1'b0;
    n   = 4'h0;
    for (int k = 0; k < 16; k++)
      if (seg_tab[k] == pat) begin hit = 1'b1; n = 4'(k); end
    m_seen[i] = 1'b1;
    if (hit) begin m_nib[i] = n; m_ok[i] = 1'b1; end
    else begin m_ok[i] = 1'b0; m_err++; end
    if (m_seen == 8'hFF) begin
      for (int k = 0; k < 8; k++) v[4*k +: 4] = m_nib[k];
      exp_q.push_back('{val: v, dv: m_ok});
      m_pushed++;
      m_seen = 8'h00;
    end
  endtask

  task automatic drive_raw(input logic [7:0] e, input logic [6:0] d, input int cyc);
    @(negedge clk);
    drv_en   = e;
    drv_disp = d;
    repeat (cyc - 1) @(negedge clk);
  endtask

  // Dwells of 40+ cycles are long enough to settle and be sampled.
  task automatic drive_digit(input int i, input logic [6:0] pat, input int cyc);
    @(negedge clk);
    drv_en   = ~(8'h01 << i);
    drv_disp = pat;
    if (cyc >= 40) mdl_sample(i, pat);
    repeat (cyc - 1) @(negedge clk);
  endtask

  task automatic scan(input logic [31:0] v, input logic [7:0] bad);
    for (int i = 0; i < 8; i++)
      drive_digit(i, bad[i] ? 7'h7F : seg_tab[v[4*i +: 4]], 64);
  endtask

  // Frame monitor: every frame_done must match the next scoreboard entry.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus0.seg_err)    n_seg++;
      if (bus1.frame_done) n_frames1++;
      if (bus0.frame_done) begin
        frame_t f;
        n_frames++;
        last_val = bus0.value;
        last_dv  = bus0.dig_valid;
        chk("frame_count", n_frames, m_pushed);
        if (exp_q.size() > 0) begin
          f = exp_q.pop_front();
          chk("frame_val", bus0.value, f.val);
          chk("frame_dv", 32'(bus0.dig_valid), 32'(f.dv));
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit");
    $fatal(1);
  end

  initial begin
    int lat, f0, f1, s0;
    for (int k = 0; k < 8; k++) m_nib[k] = 4'h0;

    #3 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_value", bus0.value, 0);
    chk("rst_dv", 32'(bus0.dig_valid), 0);
    chk("rst_fd", 32'(bus0.frame_done), 0);
    chk("rst_err", 32'(bus0.seg_err), 0);
    chk("rst_stale", 32'(bus0.stale), 1);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Static single digit, latency on the mask=01 instance.
    @(negedge clk);
    drv_en   = 8'hFE;
    drv_disp = 7'h24;
    mdl_sample(0, 7'h24);
    lat = 0;
    f1  = n_frames1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (bus1.frame_done && lat == 0) lat = k;
    end
    chk("t1_latency", lat, 20);
    chk("t1_nib", 32'(bus1.value[3:0]), 2);
    chk("t1_dv", 32'(bus1.dig_valid), 32'h01);
    chk("t1_frames", n_frames1 - f1, 1);
    chk("t1_stale", 32'(bus0.stale), 0);

    // Full scans.
    f0 = n_frames;
    scan(32'h1234ABCD, 8'h00);
    chk("t2_val", last_val, 32'h1234ABCD);
    chk("t2_dv", 32'(last_dv), 32'hFF);
    scan(32'h1234ABCD, 8'h00);
    chk("t2_frames", n_frames - f0, 2);

    // Glitch shorter than the settle window must not count.
    f0 = n_frames;
    s0 = n_seg;
    for (int i = 0; i < 7; i++) drive_digit(i, seg_tab[32'h0F1E2D3C >> (4*i) & 32'hF], 64);
    drive_digit(7, 7'h7F, 10);
    drive_digit(0, seg_tab[4'hC], 64);
    chk("t3_no_frame", n_frames - f0, 0);
    chk("t3_no_err", n_seg - s0, 0);
    drive_digit(7, seg_tab[4'h0], 64);
    chk("t3_frames", n_frames - f0, 1);
    chk("t3_val", last_val, 32'h0F1E2D3C);

    // Unrecognised pattern on digit 3 keeps the old nibble.
    s0 = n_seg;
    scan(32'h89EF5670, 8'h08);
    chk("t4_val", last_val, 32'h89EF2670);
    chk("t4_dv", 32'(last_dv), 32'hF7);
    chk("t4_err", n_seg - s0, 1);

    // Multi-anode is not a digit; then let the timeout expire.
    f0 = n_frames;
    s0 = n_seg;
    drive_raw(8'hFC, 7'h7F, 100);
    chk("t5_no_frame", n_frames - f0, 0);
    chk("t5_no_err", n_seg - s0, 0);
    chk("t5_fresh", 32'(bus0.stale), 0);
    drive_raw(8'hFF, 7'h7F, 300);
    chk("t5_stale", 32'(bus0.stale), 1);
    drive_digit(3, 7'h7F, 64);
    chk("t5_bad_keeps_stale", 32'(bus0.stale), 1);
    chk("t5_bad_err", n_seg - s0, 1);
    drive_digit(0, seg_tab[5], 64);
    chk("t5_unstale", 32'(bus0.stale), 0);

    // Reset mid-frame drops the partial frame.
    for (int i = 0; i < 5; i++) drive_digit(i, seg_tab[i + 1], 64);
    drive_digit(5, seg_tab[6], 10);
    rst_n = 1'b0;
    #1;
    chk("t6_value", bus0.value, 0);
    chk("t6_dv", 32'(bus0.dig_valid), 0);
    chk("t6_fd", 32'(bus0.frame_done), 0);
    chk("t6_err", 32'(bus0.seg_err), 0);
    chk("t6_stale", 32'(bus0.stale), 1);
    m_seen = 8'h00;
    m_ok   = 8'h00;
    for (int k = 0; k < 8; k++) m_nib[k] = 4'h0;
    drv_en   = 8'hFF;
    drv_disp = 7'h7F;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    f0 = n_frames;
    scan(32'hCAFE0123, 8'h00);
    chk("t6_frames", n_frames - f0, 1);
    chk("t6_val", last_val, 32'hCAFE0123);

    repeat (30) @(negedge clk);
    chk("sb_empty", exp_q.size(), 0);
    chk("seg_total", n_seg, m_err);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
